// File: rtl/neuron_mac_seq_pkg.sv
// Shared constants and types for the neuron MAC datapath and its helper stages.
// Values are Q8.8 signed; the FSM type is shared so neighbouring stages can decode it.
package neuron_mac_seq_pkg;

   localparam int DATA_W   = 16;
   localparam int FRAC_W   = 8;
   localparam int N_INPUTS = 18;
   localparam int SEL_W    = 5;

   localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/neuron_mac_seq_sat_trunc.sv
// Arithmetic right shift by SHIFT (floor rounding) followed by saturation to a
// signed OUT_W-bit result. Purely combinational.
module sat_trunc
   import neuron_mac_seq_pkg::*;
#(
   parameter int IN_W  = 2*DATA_W + 8,
   parameter int OUT_W = DATA_W,
   parameter int SHIFT = FRAC_W
) (
   input  logic signed [IN_W-1:0]  din,
   output logic        [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [IN_W-1:0] shifted;

   assign shifted = din >>> SHIFT;

   always_comb begin
      dout = shifted[OUT_W-1:0];
      if (shifted > MAX_V) begin
         dout = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         dout = MIN_V[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: walks an external operand mux through N_INPUTS entries, accumulates
// data*weight on top of the bias, then presents one saturated Q8.8 result with a handshake.
module neuron_mac_seq #(
   parameter int N_INPUTS = neuron_mac_seq_pkg::N_INPUTS,
   parameter int DATA_W   = neuron_mac_seq_pkg::DATA_W,
   parameter int FRAC_W   = neuron_mac_seq_pkg::FRAC_W,
   parameter int SEL_W    = neuron_mac_seq_pkg::SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   output logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] weight_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result
);

   import neuron_mac_seq_pkg::*;

   // Eight guard bits cover far more than N_INPUTS full-scale products plus the bias.
   localparam int ACC_W = 2*DATA_W + 8;
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_INPUTS - 1);

   state_t                    state_q, state_d;
   logic [SEL_W-1:0]          sel_q, sel_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]         result_q, result_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0]    bias_ext;
   logic [DATA_W-1:0]          sat_out;

   assign prod     = $signed(data_in) * $signed(weight_in);
   assign acc_sum  = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;

   // Fed from the in-flight sum so the last product lands in the registered result.
   sat_trunc #(
      .IN_W  (ACC_W),
      .OUT_W (DATA_W),
      .SHIFT (FRAC_W)
   ) u_sat_trunc (
      .din  (acc_sum),
      .dout (sat_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            if (start) begin
               acc_d   = bias_ext;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_d = acc_sum;
            if (sel_q == SEL_LAST) begin
               sel_d    = '0;
               result_d = sat_out;
               state_d  = ST_OUT;
            end else begin
               sel_d = sel_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase
   end

   assign sel       = sel_q;
   assign busy      = (state_q == ST_ACC) || (state_q == ST_OUT);
   assign out_valid = (state_q == ST_OUT);
   assign result    = result_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: constant-operand vector table, random operand
// sets scored against a behavioural model, plus stall and mid-accumulation reset sequences.
module tb_neuron_mac_seq;

   localparam int NI = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bias;
   logic [4:0]  sel;
   logic [15:0] data_in;
   logic [15:0] weight_in;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;

   logic [15:0] data_arr [NI];
   logic [15:0] w_arr    [NI];

   logic [15:0] sb_q [$];
   int n_checks = 0;
   int n_errors = 0;
   int txn_id   = 0;

   typedef struct {
      logic [15:0] d;
      logic [15:0] w;
      logic [15:0] b;
      logic [15:0] exp_r;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   neuron_mac_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .sel       (sel),
      .data_in   (data_in),
      .weight_in (weight_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // Upstream mux model: operands follow sel combinationally.
   always_comb begin
      data_in   = 16'h0000;
      weight_in = 16'h0000;
      if (sel < 5'(NI)) begin
         data_in   = data_arr[sel];
         weight_in = w_arr[sel];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] b);
      longint acc;
      acc = longint'($signed(b)) * 256;
      for (int i = 0; i < NI; i++) begin
         acc += longint'($signed(data_arr[i])) * longint'($signed(w_arr[i]));
      end
      acc = acc >>> 8;
      if (acc > 32767) return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
      return acc[15:0];
   endfunction

   task automatic fill(input logic [15:0] d, input logic [15:0] w);
      for (int i = 0; i < NI; i++) begin
         data_arr[i] = d;
         w_arr[i]    = w;
      end
   endtask

   // One evaluation: drive start, follow sel, optionally hold out_ready low for stall cycles.
   task automatic run_txn(input logic [15:0] b, input logic [15:0] exp_r, input int stall);
      int cycles;
      int sel_err;
      logic [15:0] exp_pop;
      sb_q.push_back(exp_r);
      @(negedge clk);
      bias      = b;
      start     = 1'b1;
      out_ready = (stall == 0);
      cycles    = 0;
      sel_err   = 0;
      while (cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 1) begin
            check("accept_busy", 32'(busy), 32'd1);
            start = 1'b0;
            bias  = ~b;
         end
         if (out_valid) break;
         if (sel != 5'(cycles - 1)) sel_err++;
      end
      check("latency", cycles, 32'd19);
      check("sel_walk", sel_err, 32'd0);
      if (!out_valid) begin
         exp_pop = sb_q.pop_front();
         return;
      end
      check("sel_out", 32'(sel), 32'd0);
      for (int i = 0; i < stall; i++) begin
         start = (i == 1);
         @(posedge clk);
         #1;
         cycles++;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(sb_q[0]));
      end
      start     = 1'b0;
      out_ready = 1'b1;
      exp_pop   = sb_q.pop_front();
      check("result", 32'(result), 32'(exp_pop));
      $display("txn %0d bias=%h d0=%h w0=%h result=%h expected=%h", txn_id, b, data_arr[0], w_arr[0], result, exp_pop);
      txn_id++;
      @(posedge clk);
      #1;
      cycles++;
      check("idle_after", {30'd0, busy, out_valid}, 32'd0);
      if (stall == 0) check("turnaround", cycles, 32'd20);
   endtask

   initial begin
      int cyc;
      int viol;
      logic [15:0] rb;

      vecs[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1200};
      vecs[1] = '{16'h0100, 16'hFF00, 16'h0200, 16'hF000};
      vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
      vecs[3] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
      vecs[4] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
      vecs[5] = '{16'h0200, 16'h0080, 16'h0100, 16'h1300};
      vecs[6] = '{16'hFF00, 16'hFF00, 16'hF000, 16'h0200};
      vecs[7] = '{16'h0000, 16'h1234, 16'h8000, 16'h8000};
      vecs[8] = '{16'h0080, 16'h0001, 16'h0000, 16'h0009};

      rst       = 1'b1;
      start     = 1'b0;
      bias      = 16'h0000;
      out_ready = 1'b1;
      fill(16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         fill(vecs[v].d, vecs[v].w);
         run_txn(vecs[v].b, vecs[v].exp_r, 0);
      end

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NI; i++) begin
            data_arr[i] = 16'($urandom);
            w_arr[i]    = (r < 2) ? 16'($urandom_range(0, 16'h01FF)) - 16'h0100 : 16'($urandom);
         end
         rb = 16'($urandom);
         run_txn(rb, model(rb), 0);
      end

      fill(16'h0100, 16'h0100);
      run_txn(16'h0000, 16'h1200, 5);

      // Abort mid-accumulation with an asynchronous reset.
      @(negedge clk);
      bias  = 16'h0300;
      start = 1'b1;
      cyc   = 0;
      while (cyc < 30) begin
         @(posedge clk);
         #1;
         cyc++;
         start = 1'b0;
         if (sel == 5'd9) break;
      end
      check("reach_sel9", 32'(sel), 32'd9);
      rst = 1'b1;
      #1;
      check("arst_sel", 32'(sel), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      viol = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) viol++;
      end
      check("no_ghost_result", viol, 32'd0);
      run_txn(16'h0000, 16'h1200, 0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
